// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset vector and PC step.
package cpu_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned PC_STEP          = 4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request handshake plus IF/ID output buffer handshake.
interface pc_fetch_sequencer_if #(
   parameter int unsigned INSTR_W = 32
) ();

   logic               imem_req;
   logic [31:0]        imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_instr;

   logic               if_valid;
   logic               if_ready;
   logic [INSTR_W-1:0] if_instr;
   logic [31:0]        if_pc;
   logic [31:0]        if_pc4;

   modport master (
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
      input  imem_ready, imem_instr, if_ready
   );

   modport slave (
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4,
      output imem_ready, imem_instr, if_ready
   );

endinterface

// File: rtl/jump_target_gen.sv
// Pseudo-direct J/JAL target: upper PC+4 nibble, 26-bit index, word aligned.
module jump_target_gen (
   input  logic [3:0]  pc4_hi,
   input  logic [25:0] index,
   output logic [31:0] target
);

   assign target = {pc4_hi, index, 2'b00};

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner: issues instruction fetches, buffers one fetched word
// for decode and absorbs jr/j/branch redirects, including ones racing a fetch.
module pc_fetch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned INSTR_W  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   pc_fetch_sequencer_if.master  bus,
   input  logic                  br_taken,
   input  logic [31:0]           br_target,
   input  logic                  j_taken,
   input  logic [25:0]           j_index,
   input  logic [3:0]            j_pc4_hi,
   input  logic                  jr_taken,
   input  logic [31:0]           jr_target
);

   fetch_state_t       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic               pend_q, pend_d;
   logic [31:0]        pend_target_q, pend_target_d;
   logic               if_valid_q, if_valid_d;
   logic [INSTR_W-1:0] if_instr_q, if_instr_d;
   logic [31:0]        if_pc_q, if_pc_d;
   logic [31:0]        if_pc4_q, if_pc4_d;

   logic [31:0] j_tgt;
   logic [31:0] tgt;
   logic [31:0] pc_plus4;
   logic        redir;
   logic        req_c;

   jump_target_gen u_jump_target_gen (
      .pc4_hi (j_pc4_hi),
      .index  (j_index),
      .target (j_tgt)
   );

   // Redirect priority: jr over j over branch.
   always_comb begin
      tgt = br_target;
      if (jr_taken)     tgt = jr_target;
      else if (j_taken) tgt = j_tgt;
   end

   assign redir    = jr_taken | j_taken | br_taken;
   assign pc_plus4 = pc_q + 32'(PC_STEP);

   always_comb begin
      req_c = 1'b0;
      case (state_q)
         FETCH:   req_c = !if_valid_q || bus.if_ready;
         DRAIN:   req_c = 1'b1;
         default: req_c = 1'b0;
      endcase
   end

   assign bus.imem_req  = req_c;
   assign bus.imem_addr = pc_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_instr  = if_instr_q;
   assign bus.if_pc     = if_pc_q;
   assign bus.if_pc4    = if_pc4_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_d        = pend_q;
      pend_target_d = pend_target_q;
      if_valid_d    = if_valid_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      if_pc4_d      = if_pc4_q;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (if_valid_q && bus.if_ready) if_valid_d = 1'b0;
            if (redir) begin
               if_valid_d = 1'b0;
               // An unaccepted request must stay on the bus until memory takes it.
               if (req_c && !bus.imem_ready) begin
                  pend_d        = 1'b1;
                  pend_target_d = tgt;
                  state_d       = DRAIN;
               end else begin
                  pc_d = tgt;
               end
            end else if (req_c && bus.imem_ready) begin
               if_valid_d = 1'b1;
               if_instr_d = bus.imem_instr;
               if_pc_d    = pc_q;
               if_pc4_d   = pc_plus4;
               pc_d       = pc_plus4;
            end
         end
         DRAIN: begin
            if (bus.imem_ready) begin
               pc_d    = redir ? tgt : pend_target_q;
               pend_d  = 1'b0;
               state_d = FETCH;
            end else if (redir) begin
               pend_target_d = tgt;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         pend_q        <= 1'b0;
         pend_target_q <= '0;
         if_valid_q    <= 1'b0;
         if_instr_q    <= '0;
         if_pc_q       <= '0;
         if_pc4_q      <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_q        <= pend_d;
         pend_target_q <= pend_target_d;
         if_valid_q    <= if_valid_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
         if_pc4_q      <= if_pc4_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; IF/ID output checked against a scoreboard queue.
module tb_pc_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        br_taken, j_taken, jr_taken;
   logic [31:0] br_target, jr_target;
   logic [25:0] j_index;
   logic [3:0]  j_pc4_hi;

   int unsigned errors;
   int unsigned checks;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } entry_t;

   entry_t sb[$];

   pc_fetch_sequencer_if #(.INSTR_W(32)) bus ();

   pc_fetch_sequencer #(.RESET_PC(32'h0040_0000), .INSTR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.master),
      .br_taken  (br_taken),
      .br_target (br_target),
      .j_taken   (j_taken),
      .j_index   (j_index),
      .j_pc4_hi  (j_pc4_hi),
      .jr_taken  (jr_taken),
      .jr_target (jr_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // Memory model answers combinationally on whatever address is presented.
   assign bus.imem_instr = mem_word(bus.imem_addr);

   function automatic entry_t mk(input logic [31:0] a);
      entry_t e;
      e.instr = mem_word(a);
      e.pc    = a;
      e.pc4   = a + 32'd4;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: check outputs at negedge, update scoreboard, advance past posedge.
   task automatic tick(input logic exp_req, input logic [31:0] exp_addr, input logic cap);
      logic exp_valid;
      @(negedge clk);
      check("imem_req", 32'(bus.imem_req), 32'(exp_req));
      check("imem_addr", bus.imem_addr, exp_addr);
      exp_valid = (sb.size() != 0);
      check("if_valid", 32'(bus.if_valid), 32'(exp_valid));
      if (exp_valid) begin
         check("if_instr", bus.if_instr, sb[0].instr);
         check("if_pc", bus.if_pc, sb[0].pc);
         check("if_pc4", bus.if_pc4, sb[0].pc4);
         if (bus.if_ready) void'(sb.pop_front());
      end
      if (reset || br_taken || j_taken || jr_taken) sb.delete();
      if (cap) sb.push_back(mk(exp_addr));
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      br_taken = 1'b0; j_taken = 1'b0; jr_taken = 1'b0;
      br_target = '0; jr_target = '0; j_index = '0; j_pc4_hi = '0;
      bus.imem_ready = 1'b1;
      bus.if_ready   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_addr", bus.imem_addr, 32'h0040_0000);
      check("rst_valid", 32'(bus.if_valid), 32'd0);
      check("rst_instr", bus.if_instr, 32'd0);
      check("rst_pc", bus.if_pc, 32'd0);
      check("rst_pc4", bus.if_pc4, 32'd0);
      reset = 1'b0;

      // Sequential streaming at full rate.
      tick(1'b0, 32'h0040_0000, 1'b0);
      tick(1'b1, 32'h0040_0000, 1'b1);
      tick(1'b1, 32'h0040_0004, 1'b1);
      tick(1'b1, 32'h0040_0008, 1'b1);
      tick(1'b1, 32'h0040_000C, 1'b1);

      // Decode stall: request drops, buffer held.
      bus.if_ready = 1'b0;
      repeat (3) tick(1'b0, 32'h0040_0010, 1'b0);
      bus.if_ready = 1'b1;
      tick(1'b1, 32'h0040_0010, 1'b1);
      tick(1'b1, 32'h0040_0014, 1'b1);

      // Jump with an accepted fetch.
      j_taken = 1'b1; j_index = 26'h000_0010; j_pc4_hi = 4'h0;
      tick(1'b1, 32'h0040_0018, 1'b0);
      j_taken = 1'b0;
      tick(1'b1, 32'h0000_0040, 1'b1);
      tick(1'b1, 32'h0000_0044, 1'b1);

      // Branch while memory stalls: address held, returned word dropped.
      bus.imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0100;
      tick(1'b1, 32'h0000_0048, 1'b0);
      br_taken = 1'b0;
      tick(1'b1, 32'h0000_0048, 1'b0);
      tick(1'b1, 32'h0000_0048, 1'b0);
      bus.imem_ready = 1'b1;
      tick(1'b1, 32'h0000_0048, 1'b0);
      tick(1'b1, 32'h0040_0100, 1'b1);
      tick(1'b1, 32'h0040_0104, 1'b1);

      // jr beats branch; then wrap past the top of the address space.
      jr_taken = 1'b1; jr_target = 32'hFFFF_FFF8;
      br_taken = 1'b1; br_target = 32'h1234_5678;
      tick(1'b1, 32'h0040_0108, 1'b0);
      jr_taken = 1'b0; br_taken = 1'b0;
      tick(1'b1, 32'hFFFF_FFF8, 1'b1);
      tick(1'b1, 32'hFFFF_FFFC, 1'b1);
      tick(1'b1, 32'h0000_0000, 1'b1);
      tick(1'b1, 32'h0000_0004, 1'b1);

      // j beats branch with all index bits set.
      j_taken = 1'b1; j_index = 26'h3FF_FFFF; j_pc4_hi = 4'hA;
      br_taken = 1'b1; br_target = 32'h0000_0800;
      tick(1'b1, 32'h0000_0008, 1'b0);
      j_taken = 1'b0; br_taken = 1'b0;
      tick(1'b1, 32'hAFFF_FFFC, 1'b1);

      // Redirect in the same cycle memory finally accepts the drained fetch.
      bus.imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_1000;
      tick(1'b1, 32'hB000_0000, 1'b0);
      br_target = 32'h0000_2000;
      tick(1'b1, 32'hB000_0000, 1'b0);
      br_taken = 1'b0; bus.imem_ready = 1'b1;
      jr_taken = 1'b1; jr_target = 32'h0000_3000;
      tick(1'b1, 32'hB000_0000, 1'b0);
      jr_taken = 1'b0;
      tick(1'b1, 32'h0000_3000, 1'b1);

      // Latest redirect during drain wins.
      bus.imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_5000;
      tick(1'b1, 32'h0000_3004, 1'b0);
      br_target = 32'h0000_6000;
      tick(1'b1, 32'h0000_3004, 1'b0);
      br_taken = 1'b0; bus.imem_ready = 1'b1;
      tick(1'b1, 32'h0000_3004, 1'b0);
      tick(1'b1, 32'h0000_6000, 1'b1);

      // Redirect while decode stalls still flushes the buffer.
      bus.if_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_7000;
      tick(1'b0, 32'h0000_6004, 1'b0);
      br_taken = 1'b0; bus.if_ready = 1'b1;
      tick(1'b1, 32'h0000_7000, 1'b1);

      // Reset while draining abandons the request and restarts at the reset vector.
      bus.imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_8000;
      tick(1'b1, 32'h0000_7004, 1'b0);
      br_taken = 1'b0; reset = 1'b1;
      tick(1'b1, 32'h0000_7004, 1'b0);
      reset = 1'b0;
      tick(1'b0, 32'h0040_0000, 1'b0);
      bus.imem_ready = 1'b1;
      tick(1'b1, 32'h0040_0000, 1'b1);
      tick(1'b1, 32'h0040_0004, 1'b1);
      bus.imem_ready = 1'b0;
      tick(1'b1, 32'h0040_0008, 1'b0);
      tick(1'b1, 32'h0040_0008, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
